// File: rtl/diagnosis_event_packetizer.sv
`default_nettype none
// ============================================================================
// diagnosis_event_packetizer: diagnosis event record -> DII debug packet
// Revision: 1.0
// ============================================================================
module diagnosis_event_packetizer #(
  parameter int MAX_PKT_LEN = 12,
  parameter bit LOSSY       = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [9:0]                      id,
  input  logic [15:0]                     dest,
  input  logic                            enable,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic [7:0]                      ev_id,
  input  logic [31:0]                     ev_timestamp,
  input  logic [3:0]                      ev_len,
  input  logic [16*(MAX_PKT_LEN-6)-1:0]   ev_data,
  output logic [17:0]                     debug_out,
  input  logic                            debug_out_ready
);

  localparam int         c_max_data = MAX_PKT_LEN - 6;
  localparam logic [3:0] c_len_cap  = (c_max_data > 15) ? 4'd15 : 4'(c_max_data);

  typedef enum logic [3:0] {
    S_IDLE, S_DEST, S_SRC, S_TYPE, S_EVID, S_TSLO, S_TSHI, S_DATA,
    S_ODEST, S_OSRC, S_OTYPE, S_OCNT
  } state_t;

  state_t                    r_state;
  logic [7:0]                r_ev_id;
  logic [31:0]               r_ts;
  logic [16*c_max_data-1:0]  r_data;
  logic [3:0]                r_len;
  logic [3:0]                r_idx;
  logic [15:0]               r_drop_cnt;
  logic [15:0]               r_snap;

  logic                      w_xfer;
  logic                      w_drop;
  logic [15:0]               w_word;

  assign ev_ready = rst_n & (r_state == S_IDLE) & enable & (r_drop_cnt == 16'd0);
  assign w_xfer   = debug_out[17] & debug_out_ready;
  assign w_drop   = LOSSY & ev_valid & ~ev_ready & enable;

  // r_idx always points at the next payload word to be put on the bus
  always_comb begin
    w_word = 16'd0;
    for (int k = 0; k < c_max_data; k++) begin
      if (r_idx == 4'(k)) w_word = r_data[16*k +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      debug_out  <= 18'd0;
      r_ev_id    <= 8'd0;
      r_ts       <= 32'd0;
      r_data     <= '0;
      r_len      <= 4'd0;
      r_idx      <= 4'd0;
      r_drop_cnt <= 16'd0;
      r_snap     <= 16'd0;
    end else begin
      // Snapshot cycle restarts the count, keeping a drop that lands in it
      if (r_state == S_IDLE && r_drop_cnt != 16'd0) begin
        r_drop_cnt <= {15'd0, w_drop};
      end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_drop_cnt != 16'd0) begin
            r_snap    <= r_drop_cnt;
            r_state   <= S_ODEST;
            debug_out <= {2'b10, dest};
          end else if (ev_valid && ev_ready) begin
            r_ev_id   <= ev_id;
            r_ts      <= ev_timestamp;
            r_data    <= ev_data;
            r_len     <= (ev_len > c_len_cap) ? c_len_cap : ev_len;
            r_idx     <= 4'd0;
            r_state   <= S_DEST;
            debug_out <= {2'b10, dest};
          end
        end
        default: begin
          if (w_xfer) begin
            if (debug_out[16]) begin
              r_state         <= S_IDLE;
              debug_out[17:16] <= 2'b00;
            end else begin
              case (r_state)
                S_DEST: begin
                  r_state   <= S_SRC;
                  debug_out <= {2'b10, 6'd0, id};
                end
                S_SRC: begin
                  r_state   <= S_TYPE;
                  debug_out <= {2'b10, 16'h8000};
                end
                S_TYPE: begin
                  r_state   <= S_EVID;
                  debug_out <= {2'b10, 8'd0, r_ev_id};
                end
                S_EVID: begin
                  r_state   <= S_TSLO;
                  debug_out <= {2'b10, r_ts[15:0]};
                end
                S_TSLO: begin
                  r_state   <= S_TSHI;
                  debug_out <= {1'b1, (r_len == 4'd0), r_ts[31:16]};
                end
                S_TSHI, S_DATA: begin
                  r_state   <= S_DATA;
                  r_idx     <= r_idx + 4'd1;
                  debug_out <= {1'b1, (r_idx + 4'd1 == r_len), w_word};
                end
                S_ODEST: begin
                  r_state   <= S_OSRC;
                  debug_out <= {2'b10, 6'd0, id};
                end
                S_OSRC: begin
                  r_state   <= S_OTYPE;
                  debug_out <= {2'b10, 16'h8400};
                end
                S_OTYPE: begin
                  r_state   <= S_OCNT;
                  debug_out <= {2'b11, r_snap};
                end
                default: begin
                  r_state          <= S_IDLE;
                  debug_out[17:16] <= 2'b00;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_diagnosis_event_packetizer.sv
`default_nettype none
// ============================================================================
// tb_diagnosis_event_packetizer: table vectors, directed corners, random run
// Revision: 1.0
// ============================================================================
module tb_diagnosis_event_packetizer;

  localparam int MAX_PKT_LEN = 12;
  localparam int MAX_DATA    = MAX_PKT_LEN - 6;
  localparam bit LOSSY       = 1'b1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [9:0]             id;
  logic [15:0]            dest;
  logic                   enable;
  logic                   ev_valid;
  logic                   ev_ready;
  logic [7:0]             ev_id;
  logic [31:0]            ev_timestamp;
  logic [3:0]             ev_len;
  logic [16*MAX_DATA-1:0] ev_data;
  logic [17:0]            debug_out;
  logic                   debug_out_ready;

  always #5 clk = ~clk;

  diagnosis_event_packetizer #(.MAX_PKT_LEN(MAX_PKT_LEN), .LOSSY(LOSSY)) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .dest(dest), .enable(enable),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
    .ev_timestamp(ev_timestamp), .ev_len(ev_len), .ev_data(ev_data),
    .debug_out(debug_out), .debug_out_ready(debug_out_ready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: packets as flat queues of {last,data}
  logic [16:0] exp_q[$];
  logic [16:0] mon_q[$];
  int          m_drops = 0;
  bit          m_snap = 1'b0;
  logic [17:0] out_s = 18'd0;

  typedef struct {
    logic [7:0]             eid;
    logic [31:0]            ts;
    logic [3:0]             len;
    logic [16*MAX_DATA-1:0] data;
    int                     n;
    logic [11:0][15:0]      w;
  } vec_t;
  vec_t vt[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return rst_n && exp_q.size() == 0 && enable && m_drops == 0;
  endfunction

  function automatic void push_event(input logic [7:0] eid, input logic [31:0] ts,
                                     input logic [3:0] len, input logic [16*MAX_DATA-1:0] d);
    int n = int'(len);
    if (n > MAX_DATA) n = MAX_DATA;
    exp_q.push_back({1'b0, dest});
    exp_q.push_back({1'b0, 6'd0, id});
    exp_q.push_back({1'b0, 16'h8000});
    exp_q.push_back({1'b0, 8'd0, eid});
    exp_q.push_back({1'b0, ts[15:0]});
    exp_q.push_back({(n == 0), ts[31:16]});
    for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), d[16*k +: 16]});
  endfunction

  function automatic void push_overflow(input int cnt);
    exp_q.push_back({1'b0, dest});
    exp_q.push_back({1'b0, 6'd0, id});
    exp_q.push_back({1'b0, 16'h8400});
    exp_q.push_back({1'b1, 16'(cnt)});
  endfunction

  task automatic model_update();
    bit busy, rdy, drop;
    m_snap = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_drops = 0;
      return;
    end
    if (out_s[17] && debug_out_ready) mon_q.push_back(out_s[16:0]);
    busy = (exp_q.size() != 0);
    rdy  = m_ready();
    drop = LOSSY && ev_valid && enable && !rdy;
    if (busy) begin
      if (debug_out_ready) void'(exp_q.pop_front());
      if (drop && m_drops < 65535) m_drops++;
    end else if (m_drops != 0) begin
      push_overflow(m_drops);
      m_drops = drop ? 1 : 0;
      m_snap  = 1'b1;
    end else if (ev_valid && rdy) begin
      push_event(ev_id, ev_timestamp, ev_len, ev_data);
    end
  endtask

  task automatic check_outputs();
    out_s = debug_out;
    chk("ev_ready", {31'd0, ev_ready}, {31'd0, m_ready()});
    chk("out_valid", {31'd0, debug_out[17]}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("flit", {15'd0, debug_out[16:0]}, {15'd0, exp_q[0]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input int max_cycles);
    int i = 0;
    while ((exp_q.size() != 0 || m_drops != 0) && i < max_cycles) begin
      tick();
      i++;
    end
    chk("drain_timeout", exp_q.size() + m_drops, 0);
  endtask

  task automatic send(input logic [7:0] eid, input logic [31:0] ts,
                      input logic [3:0] len, input logic [16*MAX_DATA-1:0] d);
    ev_id = eid; ev_timestamp = ts; ev_len = len; ev_data = d;
    ev_valid = 1'b1;
    tick();
  endtask

  task automatic chk_ov(input string nm, input int base, input logic [15:0] cnt);
    logic [3:0][15:0] w;
    w = {cnt, 16'h8400, {6'd0, id}, dest};
    if (base + 4 > mon_q.size()) chk({nm, "_size"}, mon_q.size(), base + 4);
    else for (int j = 0; j < 4; j++) chk(nm, {15'd0, mon_q[base+j]}, {15'd0, (j == 3), w[j]});
  endtask

  initial begin
    logic [16*MAX_DATA-1:0] d;
    id = 10'h3; dest = 16'h0000; enable = 1'b1; ev_valid = 1'b0;
    ev_id = 8'd0; ev_timestamp = 32'd0; ev_len = 4'd0; ev_data = '0;
    debug_out_ready = 1'b1;

    vt[0].eid = 8'h5A; vt[0].ts = 32'h1234_ABCD; vt[0].len = 4'd2; vt[0].n = 8;
    vt[0].data = '0; vt[0].data[31:0] = {16'hBEEF, 16'hCAFE}; vt[0].w = '0;
    vt[0].w[0] = 16'h0000; vt[0].w[1] = 16'h0003; vt[0].w[2] = 16'h8000; vt[0].w[3] = 16'h005A;
    vt[0].w[4] = 16'hABCD; vt[0].w[5] = 16'h1234; vt[0].w[6] = 16'hCAFE; vt[0].w[7] = 16'hBEEF;
    vt[1].eid = 8'h01; vt[1].ts = 32'hDEAD_0001; vt[1].len = 4'd0; vt[1].n = 6;
    vt[1].data = {MAX_DATA{16'h7777}}; vt[1].w = '0;
    vt[1].w[0] = 16'h0000; vt[1].w[1] = 16'h0003; vt[1].w[2] = 16'h8000; vt[1].w[3] = 16'h0001;
    vt[1].w[4] = 16'h0001; vt[1].w[5] = 16'hDEAD;
    vt[2].eid = 8'hFF; vt[2].ts = 32'h0001_0002; vt[2].len = 4'd15; vt[2].n = 12; vt[2].w = '0;
    for (int k = 0; k < MAX_DATA; k++) vt[2].data[16*k +: 16] = 16'h1000 + 16'(k);
    vt[2].w[0] = 16'h0000; vt[2].w[1] = 16'h0003; vt[2].w[2] = 16'h8000; vt[2].w[3] = 16'h00FF;
    vt[2].w[4] = 16'h0002; vt[2].w[5] = 16'h0001;
    for (int k = 0; k < MAX_DATA; k++) vt[2].w[6+k] = 16'h1000 + 16'(k);

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Table vectors: literal packets
    for (int v = 0; v < 3; v++) begin
      mon_q.delete();
      send(vt[v].eid, vt[v].ts, vt[v].len, vt[v].data);
      ev_valid = 1'b0;
      drain(40);
      chk($sformatf("vec%0d_len", v), mon_q.size(), vt[v].n);
      for (int k = 0; k < vt[v].n && k < mon_q.size(); k++)
        chk($sformatf("vec%0d_flit%0d", v, k), {15'd0, mon_q[k]},
            {15'd0, (k == vt[v].n - 1), vt[v].w[k]});
    end

    // Sink ready toggling every cycle
    mon_q.delete();
    send(8'h33, 32'hAAAA_5555, 4'd3, {MAX_DATA{16'h4321}});
    ev_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      debug_out_ready = ~debug_out_ready;
      tick();
    end
    debug_out_ready = 1'b1;
    drain(20);
    chk("toggle_len", mon_q.size(), 9);

    // Three dropped pulses while busy -> overflow CNT=3, then next event accepted
    mon_q.delete();
    send(8'h10, 32'h0000_0010, 4'd6, {MAX_DATA{16'h0F0F}});
    ev_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      ev_valid = 1'b1; tick();
      ev_valid = 1'b0; tick();
    end
    drain(40);
    chk_ov("ov3", 12, 16'h0003);
    send(8'h11, 32'h0000_0011, 4'd0, '0);
    ev_valid = 1'b0;
    drain(20);
    chk("ov3_next_len", mon_q.size(), 22);

    // Saturation and drop in snapshot cycle
    mon_q.delete();
    debug_out_ready = 1'b0;
    send(8'h20, 32'h0000_0020, 4'd1, {MAX_DATA{16'h2020}});
    repeat (70000) tick();
    debug_out_ready = 1'b1;
    for (int i = 0; i < 60 && !m_snap; i++) tick();
    chk("snap_seen", {31'd0, m_snap}, 32'd1);
    ev_valid = 1'b0;
    drain(60);
    chk("sat_len", mon_q.size(), 15);
    chk_ov("ov_sat", 7, 16'hFFFF);
    chk_ov("ov_snapdrop", 11, 16'h0001);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      ev_valid        = ($urandom_range(0, 3) == 0);
      enable          = ($urandom_range(0, 7) != 0);
      debug_out_ready = ($urandom_range(0, 3) != 0);
      ev_id           = 8'($urandom);
      ev_timestamp    = $urandom;
      ev_len          = 4'($urandom);
      for (int k = 0; k < MAX_DATA; k++) d[16*k +: 16] = 16'($urandom);
      ev_data = d;
      tick();
    end
    ev_valid = 1'b0; enable = 1'b1; debug_out_ready = 1'b1;
    drain(100);

    // Asynchronous reset mid-packet
    send(8'h44, 32'h4444_4444, 4'd4, {MAX_DATA{16'h4444}});
    ev_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, debug_out[17]}, 32'd0);
    chk("async_ready", {31'd0, ev_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", {31'd0, ev_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
